// File: rtl/zymason_loader.sv
// Write-side initiator for the Zymason 12-digit segment store: turns a valid/ready
// stream of 7-bit segment patterns into the store's RW/sel/pin_in programming sequence.
module zymason_loader #(
    parameter int unsigned NUM_DIGITS = 12,
    parameter int unsigned IDX_W      = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [6:0]       in_data_i,
    input  logic             in_last_i,
    output logic             tgt_reset_o,
    output logic             tgt_rw_o,
    output logic             tgt_sel_o,
    output logic [3:0]       tgt_pin_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic             frame_done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT,
        S_LO,
        S_HI,
        S_ADV,
        S_REL
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       data_q, data_d;
    logic             last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             rst_q, rst_d;
    logic             rw_q, rw_d;
    logic             sel_q, sel_d;
    logic [3:0]       pin_q, pin_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State register plus registered copies of the next-state output decode
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            rst_q   <= 1'b0;
            rw_q    <= 1'b0;
            sel_q   <= 1'b0;
            pin_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            pin_q   <= pin_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, then outputs decoded from the next state so they register glitch-free
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        rst_d   = 1'b0;
        rw_d    = 1'b0;
        sel_d   = 1'b0;
        pin_d   = '0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: if (in_valid_i) state_d = S_RST;
            S_RST: begin
                idx_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    last_d  = in_last_i;
                    state_d = S_LO;
                end
            end
            S_LO:   state_d = S_HI;
            S_HI:   state_d = (last_q || (idx_q == LAST_IDX)) ? S_REL : S_ADV;
            S_ADV: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_WAIT;
            end
            S_REL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_RST:  rst_d = 1'b1;
            S_WAIT: begin
                rw_d    = 1'b1;
                ready_d = 1'b1;
            end
            S_LO, S_ADV: begin
                rw_d  = 1'b1;
                pin_d = data_d[3:0];
            end
            S_HI: begin
                rw_d  = 1'b1;
                sel_d = 1'b1;
                pin_d = {1'b0, data_d[6:4]};
            end
            S_REL:   done_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign in_ready_o   = ready_q;
    assign tgt_reset_o  = rst_q;
    assign tgt_rw_o     = rw_q;
    assign tgt_sel_o    = sel_q;
    assign tgt_pin_o    = pin_q;
    assign busy_o       = busy_q;
    assign digit_idx_o  = idx_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_zymason_loader.sv
// Self-checking bench for zymason_loader with a behavioural model of the segment store.
module tb_zymason_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       in_last;
    logic       tgt_reset;
    logic       tgt_rw;
    logic       tgt_sel;
    logic [3:0] tgt_pin;
    logic       busy;
    logic [3:0] digit_idx;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    zymason_loader #(.NUM_DIGITS(12), .IDX_W(4)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .tgt_reset_o  (tgt_reset),
        .tgt_rw_o     (tgt_rw),
        .tgt_sel_o    (tgt_sel),
        .tgt_pin_o    (tgt_pin),
        .busy_o       (busy),
        .digit_idx_o  (digit_idx),
        .frame_done_o (frame_done)
    );

    typedef struct {
        logic [6:0] pat;
        logic [3:0] lo;
        logic [3:0] hi;
    } vec_t;

    vec_t cur [12];
    vec_t tab_count [12];
    vec_t tab_seg [12];

    // Store model: sel=0 writes the low nibble, sel=1 the high bits; a low write
    // right after a high write also advances the digit pointer.
    logic [6:0] mem [12];
    int         ptr = 0;
    logic       prev_sel = 1'b0;
    int         rst_cnt = 0;
    int         done_cnt = 0;

    initial for (int i = 0; i < 12; i++) mem[i] = 7'h0;

    always @(posedge clock) begin
        if (tgt_reset) rst_cnt <= rst_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (tgt_reset) begin
            for (int i = 0; i < 12; i++) mem[i] <= 7'h0;
            ptr      <= 0;
            prev_sel <= 1'b0;
        end else if (tgt_rw) begin
            if (tgt_sel) mem[ptr][6:4] <= tgt_pin[2:0];
            else begin
                mem[ptr][3:0] <= tgt_pin;
                if (prev_sel && ptr < 11) ptr <= ptr + 1;
            end
            prev_sel <= tgt_sel;
        end else begin
            prev_sel <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one frame from cur[], checking LO/HI pins as each digit passes.
    task automatic drive_frame(input int n, input bit use_last, input int stall_at,
                               input int stall_len, output int lat, output int rdy);
        int  k = 0;
        int  pend = 0;
        int  scnt = 0;
        int  cyc = 0;
        bit  done = 1'b0;
        rdy = 0;
        lat = -1;
        while (!done && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (in_ready) rdy++;
            if (pend == 1) begin
                chk("lo_pin", int'(tgt_pin), int'(cur[k-1].lo));
                chk("lo_sel", int'(tgt_sel), 0);
                chk("lo_idx", int'(digit_idx), k - 1);
                chk("lo_ready", int'(in_ready), 0);
                pend = 2;
            end else if (pend == 2) begin
                chk("hi_pin", int'(tgt_pin), int'(cur[k-1].hi));
                chk("hi_sel", int'(tgt_sel), 1);
                chk("hi_rw", int'(tgt_rw), 1);
                pend = 0;
            end
            if (frame_done) begin
                done = 1'b1;
                lat  = cyc - 1;
            end else begin
                if (k < n && k == stall_at && in_ready && scnt < stall_len) begin
                    scnt++;
                    in_valid = 1'b0;
                end else begin
                    in_valid = (k < n);
                end
                in_data = (k < n) ? cur[k].pat : 7'h0;
                in_last = use_last && (k == n - 1);
                if (in_valid && in_ready) begin
                    k++;
                    pend = 1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) chk("frame_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input int n, input int stall,
                               input int lat, input int rdy, input int r0, input int d0);
        @(negedge clock);
        chk({tag, "_latency"}, lat, 4 * n + 1 + stall);
        chk({tag, "_ready_cycles"}, rdy, n + stall);
        chk({tag, "_tgt_reset_pulses"}, rst_cnt - r0, 1);
        chk({tag, "_frame_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_mem%0d", tag, i), int'(mem[i]), (i < n) ? int'(cur[i].pat) : 0);
    endtask

    task automatic run(input string tag, input int n, input bit use_last,
                       input int stall_at, input int stall_len);
        int lat, rdy, r0, d0;
        r0 = rst_cnt;
        d0 = done_cnt;
        drive_frame(n, use_last, stall_at, stall_len, lat, rdy);
        check_frame(tag, n, (stall_at < n) ? stall_len : 0, lat, rdy, r0, d0);
    endtask

    initial begin
        bit found;
        int n, sa, sl;
        logic [6:0] p;

        tab_seg = '{
            '{7'h7F, 4'hF, 4'h7}, '{7'h06, 4'h6, 4'h0}, '{7'h5B, 4'hB, 4'h5},
            '{7'h4F, 4'hF, 4'h4}, '{7'h66, 4'h6, 4'h6}, '{7'h6D, 4'hD, 4'h6},
            '{7'h7D, 4'hD, 4'h7}, '{7'h07, 4'h7, 4'h0}, '{7'h7F, 4'hF, 4'h7},
            '{7'h6F, 4'hF, 4'h6}, '{7'h77, 4'h7, 4'h7}, '{7'h7C, 4'hC, 4'h7}
        };
        tab_count = '{
            '{7'h00, 4'h0, 4'h0}, '{7'h01, 4'h1, 4'h0}, '{7'h02, 4'h2, 4'h0},
            '{7'h03, 4'h3, 4'h0}, '{7'h04, 4'h4, 4'h0}, '{7'h05, 4'h5, 4'h0},
            '{7'h06, 4'h6, 4'h0}, '{7'h07, 4'h7, 4'h0}, '{7'h08, 4'h8, 4'h0},
            '{7'h09, 4'h9, 4'h0}, '{7'h0A, 4'hA, 4'h0}, '{7'h0B, 4'hB, 4'h0}
        };

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 7'h0;
        in_last  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_tgt_reset", int'(tgt_reset), 0);
        chk("rst_rw", int'(tgt_rw), 0);
        chk("rst_sel", int'(tgt_sel), 0);
        chk("rst_pin", int'(tgt_pin), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(digit_idx), 0);
        chk("rst_done", int'(frame_done), 0);
        reset = 1'b0;
        @(negedge clock);

        // Full 12-digit counting frame, valid held high
        cur = tab_count;
        run("count12", 12, 1'b0, 12, 0);

        // Segment frame co-simulated with the store
        cur = tab_seg;
        run("seg12", 12, 1'b0, 12, 0);

        // Early end on digit 3
        run("last3", 4, 1'b1, 4, 0);

        // Five-cycle stall in WAIT before digit 3
        run("stall", 12, 1'b0, 3, 5);

        // Back-to-back frames overwrite the previous contents
        cur = tab_count;
        run("b2b_a", 12, 1'b1, 12, 0);
        cur = tab_seg;
        run("b2b_b", 12, 1'b0, 12, 0);

        // Reset asserted while the loader is in HI
        in_valid = 1'b1;
        in_data  = cur[0].pat;
        found    = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (tgt_sel) begin
                found    = 1'b1;
                reset    = 1'b1;
                in_valid = 1'b0;
            end
        end
        chk("hi_reached", int'(found), 1);
        @(negedge clock);
        chk("midrst_rw", int'(tgt_rw), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tgt_reset", int'(tgt_reset), 0);
        chk("midrst_idx", int'(digit_idx), 0);
        chk("midrst_ready", int'(in_ready), 0);
        reset = 1'b0;
        @(negedge clock);

        // Randomized frames with random lengths, stalls and gaps
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < 12; i++) begin
                p = 7'($urandom_range(0, 127));
                cur[i].pat = p;
                cur[i].lo  = 4'(p % 16);
                cur[i].hi  = 4'(p / 16);
            end
            sa = $urandom_range(0, n);
            sl = $urandom_range(1, 6);
            run($sformatf("rnd%0d", f), n, (n < 12) ? 1'b1 : 1'($urandom_range(0, 1)), sa, sl);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
